// File: rtl/regfile.sv
// regfile: 32x32 architectural register file with ROB rename tags and operand bypass
module regfile #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 dec_ready,
  input  logic [4:0]           dec_rd,
  input  logic [ROB_WIDTH-1:0] dec_rob_id,
  input  logic [4:0]           dec_rs1,
  input  logic [4:0]           dec_rs2,
  output logic [31:0]          rs1_val,
  output logic [31:0]          rs2_val,
  output logic                 rs1_dep,
  output logic                 rs2_dep,
  output logic [ROB_WIDTH-1:0] rs1_tag,
  output logic [ROB_WIDTH-1:0] rs2_tag,
  output logic [ROB_WIDTH-1:0] search_rob_id_1,
  output logic [ROB_WIDTH-1:0] search_rob_id_2,
  input  logic                 search_ready_1,
  input  logic                 search_ready_2,
  input  logic [31:0]          search_val_1,
  input  logic [31:0]          search_val_2,
  input  logic                 commit_ready,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic [4:0]           commit_reg_id,
  input  logic [31:0]          commit_val
);
  logic [31:0]          val_q  [32];
  logic [31:0]          val_d  [32];
  logic [ROB_WIDTH-1:0] tag_q  [32];
  logic [ROB_WIDTH-1:0] tag_d  [32];
  logic [31:0]          busy_q;
  logic [31:0]          busy_d;
  logic                 hit1, hit2, wr_c, wr_i;

  assign search_rob_id_1 = tag_q[dec_rs1];
  assign search_rob_id_2 = tag_q[dec_rs2];
  assign hit1 = commit_ready && commit_rob_id == tag_q[dec_rs1];
  assign hit2 = commit_ready && commit_rob_id == tag_q[dec_rs2];
  assign wr_c = rdy_in && commit_ready && commit_reg_id != 5'd0;
  assign wr_i = rdy_in && dec_ready && dec_rd != 5'd0 && !clear;

  // Operand resolution from pre-issue state: register, then commit bypass, then ROB search
  always_comb begin
    rs1_val = !busy_q[dec_rs1] ? val_q[dec_rs1] : hit1 ? commit_val : search_ready_1 ? search_val_1 : 32'd0;
    rs2_val = !busy_q[dec_rs2] ? val_q[dec_rs2] : hit2 ? commit_val : search_ready_2 ? search_val_2 : 32'd0;
    rs1_dep = busy_q[dec_rs1] && !hit1 && !search_ready_1;
    rs2_dep = busy_q[dec_rs2] && !hit2 && !search_ready_2;
    rs1_tag = rs1_dep ? tag_q[dec_rs1] : '0;
    rs2_tag = rs2_dep ? tag_q[dec_rs2] : '0;
  end

  // Next state: commit writes value and retires matching tag; issue renames last so it wins
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = clear && rdy_in ? 32'd0 : busy_q;
    if (wr_c) val_d[commit_reg_id] = commit_val;
    if (wr_c && !clear && tag_q[commit_reg_id] == commit_rob_id) busy_d[commit_reg_id] = 1'b0;
    if (wr_i) begin
      tag_d[dec_rd]  = dec_rob_id;
      busy_d[dec_rd] = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < 32; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      val_q  <= val_d;
      tag_q  <= tag_d;
    end
  end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile
module tb_regfile;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, dec_ready;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2, commit_reg_id;
  logic [3:0]  dec_rob_id, commit_rob_id;
  logic [31:0] rs1_val, rs2_val, search_val_1, search_val_2, commit_val;
  logic        rs1_dep, rs2_dep, search_ready_1, search_ready_2, commit_ready;
  logic [3:0]  rs1_tag, rs2_tag, search_rob_id_1, search_rob_id_2;
  int          checks = 0;
  int          failures = 0;

  regfile #(.ROB_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .dec_ready(dec_ready), .dec_rd(dec_rd), .dec_rob_id(dec_rob_id),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_dep(rs1_dep), .rs2_dep(rs2_dep),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .search_rob_id_1(search_rob_id_1), .search_rob_id_2(search_rob_id_2),
    .search_ready_1(search_ready_1), .search_ready_2(search_ready_2),
    .search_val_1(search_val_1), .search_val_2(search_val_2),
    .commit_ready(commit_ready), .commit_rob_id(commit_rob_id),
    .commit_reg_id(commit_reg_id), .commit_val(commit_val)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst_in = 0; rdy_in = 1; clear = 0; dec_ready = 0; dec_rd = 0; dec_rob_id = 0;
    search_ready_1 = 0; search_ready_2 = 0; search_val_1 = 0; search_val_2 = 0;
    commit_ready = 0; commit_rob_id = 0; commit_reg_id = 0; commit_val = 0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    idle();
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] rob);
    dec_ready = 1; dec_rd = rd; dec_rob_id = rob;
  endtask

  task automatic commit(input logic [4:0] rg, input logic [3:0] rob, input logic [31:0] v);
    commit_ready = 1; commit_reg_id = rg; commit_rob_id = rob; commit_val = v;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    dec_rs1 = a; dec_rs2 = b;
    #1;
  endtask

  initial begin
    idle();
    dec_rs1 = 0; dec_rs2 = 0;
    rst_in = 1;
    @(posedge clk_in); #1;
    rst_in = 1;
    @(posedge clk_in); #1;
    idle();
    rd(5, 0);
    chk("rst_rs1_val", rs1_val, 0);
    chk("rst_rs1_dep", {31'd0, rs1_dep}, 0);
    chk("rst_rs2_val", rs2_val, 0);
    chk("rst_rs2_dep", {31'd0, rs2_dep}, 0);
    chk("rst_rs1_tag", {28'd0, rs1_tag}, 0);

    issue(3, 7);
    rd(3, 3);
    chk("pre_issue_dep", {31'd0, rs1_dep}, 0);
    step();
    rd(3, 0);
    chk("tagged_dep", {31'd0, rs1_dep}, 1);
    chk("tagged_tag", {28'd0, rs1_tag}, 7);
    chk("tagged_val", rs1_val, 0);
    chk("search_id", {28'd0, search_rob_id_1}, 7);
    search_ready_1 = 1; search_val_1 = 32'hAB;
    rd(3, 0);
    chk("search_dep", {31'd0, rs1_dep}, 0);
    chk("search_val", rs1_val, 32'hAB);
    chk("search_tag0", {28'd0, rs1_tag}, 0);
    commit(3, 7, 32'h55);
    rd(3, 0);
    chk("commit_bypass", rs1_val, 32'h55);
    step();
    rd(3, 0);
    chk("commit_ret_dep", {31'd0, rs1_dep}, 0);
    chk("commit_ret_val", rs1_val, 32'h55);

    issue(3, 2);
    step();
    issue(3, 5);
    step();
    commit(3, 2, 32'h11);
    step();
    rd(3, 0);
    chk("stale_commit_dep", {31'd0, rs1_dep}, 1);
    chk("stale_commit_tag", {28'd0, rs1_tag}, 5);

    commit(4, 1, 32'h22);
    issue(4, 9);
    step();
    rd(0, 4);
    chk("same_reg_dep", {31'd0, rs2_dep}, 1);
    chk("same_reg_tag", {28'd0, rs2_tag}, 9);

    issue(6, 10);
    step();
    issue(7, 11);
    step();
    issue(8, 13);
    clear = 1;
    commit(6, 12, 32'h33);
    step();
    rd(6, 7);
    chk("clr_x6_val", rs1_val, 32'h33);
    chk("clr_x6_dep", {31'd0, rs1_dep}, 0);
    chk("clr_x7_dep", {31'd0, rs2_dep}, 0);
    rd(8, 3);
    chk("clr_x8_dep", {31'd0, rs1_dep}, 0);
    chk("clr_x8_val", rs1_val, 0);
    chk("clr_x3_val", rs2_val, 32'h11);
    rd(4, 0);
    chk("clr_x4_val", rs1_val, 32'h22);
    chk("clr_x4_dep", {31'd0, rs1_dep}, 0);

    issue(0, 3);
    step();
    rd(0, 0);
    chk("x0_issue_dep", {31'd0, rs1_dep}, 0);
    commit(0, 3, 32'hFF);
    step();
    rd(0, 0);
    chk("x0_commit_val", rs1_val, 0);
    rdy_in = 0;
    issue(2, 4);
    commit(5, 0, 32'h77);
    rd(3, 0);
    chk("rdy_low_comb", rs1_val, 32'h11);
    @(posedge clk_in); #1;
    rdy_in = 0; issue(2, 4); commit(5, 0, 32'h77);
    step();
    rd(2, 5);
    chk("rdy_low_x2_dep", {31'd0, rs1_dep}, 0);
    chk("rdy_low_x5_val", rs2_val, 0);

    rst_in = 1;
    issue(9, 6);
    commit(3, 0, 32'h99);
    step();
    rd(9, 3);
    chk("rst_prio_dep", {31'd0, rs1_dep}, 0);
    chk("rst_prio_val", rs2_val, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
